// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit.
// Default geometry and FSM/source encodings.
package pc_unit_pkg;

  localparam int          PC_BUS_WIDTH    = 32;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0;
  localparam int          PC_INCR         = 4;
  localparam int          PC_ALIGN_BITS   = 2;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_PEND_REDIR,
    PC_PEND_TRAP
  } pc_state_e;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_REDIR,
    SRC_TRAP
  } pc_src_e;

endpackage

// File: rtl/pc_unit_next_sel.sv
// Next-PC priority mux and redirect alignment check.
// Priority: new trap > pending trap > new redirect > pending redirect > sequential.
module pc_unit_next_sel
  import pc_unit_pkg::*;
#(
  parameter int BUS_WIDTH  = PC_BUS_WIDTH,
  parameter int INCR       = PC_INCR,
  parameter int ALIGN_BITS = PC_ALIGN_BITS
) (
  input  pc_state_e            state,
  input  logic                 redir_valid,
  input  logic [BUS_WIDTH-1:0] redir_target,
  input  logic                 trap_valid,
  input  logic [BUS_WIDTH-1:0] trap_vec,
  input  logic [BUS_WIDTH-1:0] ptgt,
  input  logic [BUS_WIDTH-1:0] curr_addr,
  output logic [BUS_WIDTH-1:0] trap_tgt,
  output logic [BUS_WIDTH-1:0] target,
  output logic                 misalign
);

  localparam logic [BUS_WIDTH-1:0] STEP = BUS_WIDTH'(INCR);
  localparam logic [BUS_WIDTH-1:0] AMASK =
    {{(BUS_WIDTH-ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};

  pc_src_e src;

  assign trap_tgt = trap_vec & AMASK;

  always_comb begin
    src    = SRC_SEQ;
    target = curr_addr + STEP;
    if (trap_valid) begin
      src    = SRC_TRAP;
      target = trap_tgt;
    end else if (state == PC_PEND_TRAP) begin
      src    = SRC_TRAP;
      target = ptgt;
    end else if (redir_valid) begin
      src    = SRC_REDIR;
      target = redir_target;
    end else if (state == PC_PEND_REDIR) begin
      src    = SRC_REDIR;
      target = ptgt;
    end
  end

  assign misalign = (src == SRC_REDIR) &&
                    (target[ALIGN_BITS-1:0] != '0);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC, next-PC select, pending redirect/trap latch.
// prev_addr keeps the PC of the executing instruction for link/AUIPC/mepc.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                   BUS_WIDTH    = PC_BUS_WIDTH,
  parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = BUS_WIDTH'(PC_RESET_VECTOR),
  parameter int                   INCR         = PC_INCR,
  parameter int                   ALIGN_BITS   = PC_ALIGN_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PC_Update,
  input  logic                 redir_valid,
  input  logic [BUS_WIDTH-1:0] redir_target,
  input  logic                 trap_valid,
  input  logic [BUS_WIDTH-1:0] trap_vec,
  output logic [BUS_WIDTH-1:0] curr_addr,
  output logic [BUS_WIDTH-1:0] prev_addr,
  output logic                 pend,
  output logic                 misalign_err,
  output logic [BUS_WIDTH-1:0] misalign_addr
);

  pc_state_e            state_q;
  pc_state_e            state_d;
  logic [BUS_WIDTH-1:0] ptgt_q;
  logic [BUS_WIDTH-1:0] trap_tgt;
  logic [BUS_WIDTH-1:0] target;
  logic                 misalign;
  logic                 take_redir;

  pc_unit_next_sel #(
    .BUS_WIDTH  (BUS_WIDTH),
    .INCR       (INCR),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_sel (
    .state        (state_q),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .trap_valid   (trap_valid),
    .trap_vec     (trap_vec),
    .ptgt         (ptgt_q),
    .curr_addr    (curr_addr),
    .trap_tgt     (trap_tgt),
    .target       (target),
    .misalign     (misalign)
  );

  // A pending trap swallows any new redirect.
  assign take_redir = redir_valid && (state_q != PC_PEND_TRAP);
  assign pend       = (state_q != PC_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PC_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (PC_Update)       state_d = PC_IDLE;
    else if (trap_valid) state_d = PC_PEND_TRAP;
    else if (take_redir) state_d = PC_PEND_REDIR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr_addr     <= RESET_VECTOR;
      prev_addr     <= RESET_VECTOR;
      ptgt_q        <= '0;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_err <= 1'b0;
      if (PC_Update) begin
        if (misalign) begin
          misalign_err  <= 1'b1;
          misalign_addr <= target;
        end else begin
          prev_addr <= curr_addr;
          curr_addr <= target;
        end
      end else if (trap_valid) begin
        ptgt_q <= trap_tgt;
      end else if (take_redir) begin
        ptgt_q <= redir_target;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PC_Update = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vec = '0;
  logic [31:0] curr_addr;
  logic [31:0] prev_addr;
  logic        pend;
  logic        misalign_err;
  logic [31:0] misalign_addr;

  pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .PC_Update     (PC_Update),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .trap_valid    (trap_valid),
    .trap_vec      (trap_vec),
    .curr_addr     (curr_addr),
    .prev_addr     (prev_addr),
    .pend          (pend),
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] curr;
    logic [31:0] prev;
    logic        pend;
    logic        err;
    logic [31:0] maddr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input exp_t e);
    logic ok;
    ok = (curr_addr === e.curr) && (prev_addr === e.prev) &&
         (pend === e.pend) && (misalign_err === e.err) &&
         (!e.err || misalign_addr === e.maddr);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got curr=%h prev=%h pend=%b err=%b maddr=%h, want curr=%h prev=%h pend=%b err=%b maddr=%h",
                  e.name, curr_addr, prev_addr, pend, misalign_err,
                  misalign_addr, e.curr, e.prev, e.pend, e.err, e.maddr);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      compare(q[0]);
      void'(q.pop_front());
    end
  end

  // Called at a negedge: drive inputs, queue the post-edge expectation.
  task automatic step(input string nm, input logic upd,
                      input logic rv, input logic [31:0] rt,
                      input logic tv, input logic [31:0] tvec,
                      input logic [31:0] ec, input logic [31:0] ep,
                      input logic epend, input logic eerr,
                      input logic [31:0] emaddr);
    exp_t e;
    PC_Update    = upd;
    redir_valid  = rv;
    redir_target = rt;
    trap_valid   = tv;
    trap_vec     = tvec;
    e.cyc   = cyc + 1;
    e.name  = nm;
    e.curr  = ec;
    e.prev  = ep;
    e.pend  = epend;
    e.err   = eerr;
    e.maddr = emaddr;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic seq(input string nm, input logic [31:0] ec,
                     input logic [31:0] ep);
    step(nm, 1, 0, 0, 0, 0, ec, ep, 0, 0, 0);
  endtask

  initial begin
    exp_t r;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r.name = "reset_state"; r.curr = 0; r.prev = 0;
    r.pend = 0; r.err = 0; r.maddr = 0;
    compare(r);
    total++;
    if (misalign_addr === 32'h0) passed++;
    else $display("FAIL reset_maddr: got %h want 0", misalign_addr);

    step("idle",        0, 0, 0,     0, 0, 32'h0,  32'h0,  0, 0, 0);
    step("latch_40",    0, 1, 'h40,  0, 0, 32'h0,  32'h0,  1, 0, 0);
    step("commit_40",   1, 0, 0,     0, 0, 32'h40, 32'h0,  0, 0, 0);
    seq ("seq_44",      32'h44, 32'h40);
    step("latch_80",    0, 1, 'h80,  0, 0, 32'h44, 32'h40, 1, 0, 0);

    #2 rst = 1'b1;
    #1;
    r.name = "async_reset"; r.curr = 0; r.prev = 0;
    r.pend = 0; r.err = 0; r.maddr = 0;
    compare(r);
    @(negedge clk);
    rst = 1'b0;

    seq ("post_rst_4",  32'h4, 32'h0);
    seq ("post_rst_8",  32'h8, 32'h4);
    seq ("post_rst_c",  32'hC, 32'h8);

    step("direct_100",  1, 1, 'h100, 0, 0, 32'h100, 32'hC,   0, 0, 0);
    step("latch_200",   0, 1, 'h200, 0, 0, 32'h100, 32'hC,   1, 0, 0);
    step("wait_200",    0, 0, 0,     0, 0, 32'h100, 32'hC,   1, 0, 0);
    step("commit_200",  1, 0, 0,     0, 0, 32'h200, 32'h100, 0, 0, 0);

    step("latch_240",   0, 1, 'h240, 0, 0,     32'h200, 32'h100, 1, 0, 0);
    step("trap_803",    0, 0, 0,     1, 'h803, 32'h200, 32'h100, 1, 0, 0);
    step("redir_drop",  0, 1, 'h300, 0, 0,     32'h200, 32'h100, 1, 0, 0);
    step("commit_trap", 1, 0, 0,     0, 0,     32'h800, 32'h200, 0, 0, 0);

    step("latch_240b",  0, 1, 'h240, 0, 0, 32'h800, 32'h200, 1, 0, 0);
    step("latch_280",   0, 1, 'h280, 0, 0, 32'h800, 32'h200, 1, 0, 0);
    step("newest_wins", 1, 0, 0,     0, 0, 32'h280, 32'h800, 0, 0, 0);

    step("misalign_202", 1, 1, 'h202, 0, 0, 32'h280, 32'h800, 0, 1, 32'h202);
    step("err_clear",    0, 0, 0,     0, 0, 32'h280, 32'h800, 0, 0, 0);
    step("latch_301",    0, 1, 'h301, 0, 0, 32'h280, 32'h800, 1, 0, 0);
    step("misalign_301", 1, 0, 0,     0, 0, 32'h280, 32'h800, 0, 1, 32'h301);
    step("err_clear2",   0, 0, 0,     0, 0, 32'h280, 32'h800, 0, 0, 0);

    step("trap_vs_redir", 1, 1, 'h204, 1, 'h900, 32'h900, 32'h280, 0, 0, 0);
    step("latch_400",     0, 1, 'h400, 0, 0,     32'h900, 32'h280, 1, 0, 0);
    step("trap_replace",  0, 0, 0,     1, 'hA02, 32'h900, 32'h280, 1, 0, 0);
    step("commit_a00",    1, 0, 0,     0, 0,     32'hA00, 32'h900, 0, 0, 0);

    step("jump_top", 1, 1, 'hFFFF_FFFC, 0, 0,
         32'hFFFF_FFFC, 32'hA00, 0, 0, 0);
    seq ("wrap_0",   32'h0, 32'hFFFF_FFFC);
    seq ("wrap_4",   32'h4, 32'h0);

    PC_Update = 0; redir_valid = 0; trap_valid = 0;
    @(negedge clk);
    #1;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
